// File: rtl/controlador_lcd.sv
// HD44780 write-only controller, 8-bit mode.
// Sequence: power-up wait, four-command init, then upstream writes.
// Optional macro LCD_CLEAR_DELAY_EN: clear/home instructions get the long
// 2000 us transfer time instead of 50 us.
module controlador_lcd #(
  parameter int unsigned CLK_FREQ_MHZ = 50,
  parameter int unsigned POWERUP_US   = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_enable,
  input  logic [9:0] lcd_bus,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       lcd_on
);

  localparam int unsigned F       = CLK_FREQ_MHZ;
  localparam int unsigned PU_CYC  = POWERUP_US * F;
  localparam int unsigned T_STD   = 50 * F;
  localparam int unsigned T_CLR   = 2000 * F;
  localparam int unsigned MAX_CNT = (PU_CYC > T_CLR) ? PU_CYC : T_CLR;
  localparam int unsigned CW      = ($clog2(MAX_CNT + 1) > 22) ? $clog2(MAX_CNT + 1) : 22;

  typedef enum logic [1:0] {POWER_UP, INIT, READY, SEND} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    step_q, step_d;
  logic          rs_q, rs_d, rw_q, rw_d;
  logic [7:0]    data_q, data_d;
  logic [CW-1:0] t_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Final count value of the transfer in progress (T-1).
`ifdef LCD_CLEAR_DELAY_EN
  assign t_last = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? CW'(T_CLR - 1) : CW'(T_STD - 1);
`else
  assign t_last = CW'(T_STD - 1);
`endif

  // State, counter and latched bus registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= POWER_UP;
      cnt_q   <= '0;
      step_q  <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic. INIT steps reuse the SEND timing directly, loading the
  // next command as each step ends so the bus is valid from n=0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    data_d  = data_q;
    case (state_q)
      POWER_UP: begin
        if (cnt_q == CW'(PU_CYC - 1)) begin
          state_d = INIT;
          cnt_d   = '0;
          step_d  = '0;
          rs_d    = 1'b0;
          rw_d    = 1'b0;
          data_d  = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INIT, SEND: begin
        if (cnt_q == t_last) begin
          cnt_d = '0;
          if (state_q == INIT && step_q != 2'd3) begin
            step_d = step_q + 2'd1;
            data_d = init_cmd(step_q + 2'd1);
          end else begin
            state_d = READY;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (lcd_enable) begin
          state_d = SEND;
          cnt_d   = '0;
          rs_d    = lcd_bus[9];
          rw_d    = lcd_bus[8];
          data_d  = lcd_bus[7:0];
        end
      end
      default: state_d = POWER_UP;
    endcase
  end

  assign lcd_e    = (state_q == INIT || state_q == SEND) &&
                    (cnt_q >= CW'(F)) && (cnt_q < CW'(15 * F));
  assign busy     = (state_q != READY);
  assign lcd_rs   = rs_q;
  assign lcd_rw   = rw_q;
  assign lcd_data = data_q;
  assign lcd_on   = 1'b1;

endmodule

// File: tb/tb_controlador_lcd.sv
// Scoreboard bench for controlador_lcd: stimulus pushes expected transfers,
// a negedge monitor pops them on each lcd_e rise and checks bus and timing.
module tb_controlador_lcd;

  localparam int unsigned F  = 1;
  localparam int unsigned PU = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_enable = 1'b0;
  logic [9:0] lcd_bus = '0;
  logic       busy, lcd_rs, lcd_rw, lcd_e, lcd_on;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  controlador_lcd #(.CLK_FREQ_MHZ(F), .POWERUP_US(PU)) dut (
    .clk(clk), .rst(rst), .lcd_enable(lcd_enable), .lcd_bus(lcd_bus),
    .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .lcd_on(lcd_on)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  typedef struct {
    logic [9:0]  bus;
    int          t;
  } xfer_t;

  xfer_t exp_q[$];

  // Reference transfer length in cycles.
  function automatic int t_of(input logic [9:0] b);
    int t;
    t = 50 * F;
`ifdef LCD_CLEAR_DELAY_EN
    if (b[9] == 1'b0 && (b[7:0] == 8'h01 || b[7:0] == 8'h02)) t = 2000 * F;
`endif
    return t;
  endfunction

  function automatic void push(input logic [9:0] b);
    xfer_t x;
    x.bus = b;
    x.t   = t_of(b);
    exp_q.push_back(x);
  endfunction

  // Monitor: pulse content, pulse width, step period and busy length.
  int    cyc = 0;
  int    rise_t = 0;
  logic  e_prev = 1'b0;
  logic  b_prev = 1'b1;
  logic  pending = 1'b0;
  xfer_t cur;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      pending = 1'b0;
      e_prev  = 1'b0;
      b_prev  = 1'b1;
    end else begin
      if (lcd_e && !e_prev) begin
        if (pending) check("step_period", cyc - rise_t, cur.t);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: lcd_e rose at cycle %0d with no transfer queued", cyc);
          pending = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("rs_rw_data", int'({lcd_rs, lcd_rw, lcd_data}), int'(cur.bus));
          rise_t  = cyc;
          pending = 1'b1;
        end
      end
      if (!lcd_e && e_prev) check("e_width", cyc - rise_t, 14 * F);
      if (!busy && b_prev && pending) begin
        check("busy_len", cyc - rise_t, cur.t - 1);
        pending = 1'b0;
      end
      e_prev = lcd_e;
      b_prev = busy;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: busy still 1 after 5000 cycles, required 0");
    end
  endtask

  // Waits for READY, presents one request, returns #1 after the accepting edge.
  task automatic send(input logic [9:0] b);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      lcd_bus    = b;
      lcd_enable = 1'b1;
      push(b);
      @(posedge clk);
      #1 lcd_enable = 1'b0;
    end
  endtask

  // Releases rst (already asserted), queues the init sequence and checks
  // the power-up wait: PU*F POWER_UP cycles plus INIT's n=0 cycle before lcd_e.
  task automatic finish_reset();
    int n;
    bit busy_ok;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push({2'b00, 8'h38});
    push({2'b00, 8'h0C});
    push({2'b00, 8'h01});
    push({2'b00, 8'h06});
    n = 0;
    busy_ok = 1'b1;
    while (n < 5000) begin
      @(negedge clk);
      if (lcd_e) break;
      if (!busy) busy_ok = 1'b0;
      n++;
    end
    check("powerup_cycles", n, PU * F + F);
    check("powerup_busy", int'(busy_ok), 1);
  endtask

  initial begin
    bit ok;
    logic [9:0] b;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 1);
    check("rst_e", int'(lcd_e), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_rw", int'(lcd_rw), 0);
    check("rst_data", int'(lcd_data), 0);
    check("rst_on", int'(lcd_on), 1);
    finish_reset();

    // Character write 'F'
    send(10'b10_01000110);
    @(negedge clk);
    check("char_busy", int'(busy), 1);
    check("char_rs", int'(lcd_rs), 1);
    check("char_data", int'(lcd_data), 8'h46);
    wait_ready(ok);
    check("ready_hold_rs", int'(lcd_rs), 1);
    check("ready_hold_data", int'(lcd_data), 8'h46);
    check("lcd_on", int'(lcd_on), 1);

    // Clear instruction (long or short depending on build)
    send(10'b00_00000001);

    // Random single requests
    for (int i = 0; i < 20; i++) begin
      b = 10'($urandom);
      send(b);
    end

    // Back-to-back: lcd_enable held high across 34 requests
    for (int i = 0; i < 34; i++) begin
      wait_ready(ok);
      if (!ok) break;
      b = 10'($urandom);
      lcd_bus    = b;
      lcd_enable = 1'b1;
      push(b);
      @(posedge clk);
      #1 if (i == 33) lcd_enable = 1'b0;
      @(negedge clk);
      check("b2b_accept", int'(busy), 1);
    end

    // Bus change at n=5 must not disturb the transfer
    b = {2'b10, 8'hA5};
    send(b);
    repeat (5) @(posedge clk);
    #1 lcd_bus = ~b;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      check("held_bus", int'({lcd_rs, lcd_rw, lcd_data}), int'(b));
      if (!busy) break;
    end

    // Reset at n=8 of a SEND
    send({2'b10, 8'h5A});
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_e", int'(lcd_e), 0);
    check("midrst_busy", int'(busy), 1);
    check("midrst_data", int'(lcd_data), 0);
    finish_reset();

    // Normal operation after the restart
    send({2'b10, 8'h33});
    wait_ready(ok);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
